// File: rtl/req_arbiter.sv
// Purpose : 4-way request arbiter (fixed priority or round-robin) with a registered one-hot grant and a hold limit.
// Latency : req sampled at edge k -> gnt visible after edge k; each release/timeout inserts exactly 1 dead cycle.
// Backpressure: en=0 blocks new grants only; the current owner keeps the grant until it drops req or hits MAX_HOLD.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   en        - allow new grants
//   rr_mode   - 0 = fixed priority (req[3] highest), 1 = round-robin; used only when arbitrating
//   req[3:0]  - request vector; the owner holds its bit high to keep the grant
//   gnt[3:0]  - registered one-hot grant, 0 when there is no owner
//   gnt_id    - binary owner index (mux select), 0 when there is no owner
//   gnt_valid - |gnt
//   timeout   - one-cycle pulse during the dead cycle that follows a forced release
module req_arbiter #(
  parameter int unsigned MAX_HOLD = 16,  // legal 2..255
  parameter int unsigned CW       = 8    // 2**CW must exceed MAX_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rr_mode,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    REL  = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic [1:0]    rr_ptr, rr_ptr_nxt;
  logic [3:0]    excl, excl_nxt;
  logic [3:0]    gnt_nxt;
  logic [1:0]    gnt_id_nxt;
  logic          timeout_nxt;

  logic [3:0]    cand;
  logic          win_found;
  logic [1:0]    win_id;
  logic [1:0]    rr_idx;

  // Winner selection. Both loops let the last matching iteration win:
  // round-robin walks offsets downwards so the smallest offset from rr_ptr
  // wins; fixed priority walks upwards so the highest index wins.
  always_comb begin
    cand      = req & ~excl;
    win_found = |cand;
    win_id    = 2'd0;
    rr_idx    = 2'd0;
    if (rr_mode) begin
      for (int i = 3; i >= 0; i--) begin
        rr_idx = rr_ptr + 2'(i);
        if (cand[rr_idx]) win_id = rr_idx;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cand[i]) win_id = 2'(i);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    gnt_id_nxt   = gnt_id;
    hold_cnt_nxt = hold_cnt;
    rr_ptr_nxt   = rr_ptr;
    excl_nxt     = excl;
    timeout_nxt  = 1'b0;

    case (state)
      IDLE, REL: begin
        // The exclusion mask only ever covers one arbitration.
        excl_nxt = '0;
        if (en && win_found) begin
          state_nxt    = BUSY;
          gnt_nxt      = 4'b0001 << win_id;
          gnt_id_nxt   = win_id;
          hold_cnt_nxt = '0;
        end else begin
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          gnt_id_nxt = '0;
        end
      end

      BUSY: begin
        if (!req[gnt_id] || hold_cnt == HOLD_LAST) begin
          state_nxt    = REL;
          gnt_nxt      = '0;
          gnt_id_nxt   = '0;
          hold_cnt_nxt = '0;
          rr_ptr_nxt   = gnt_id + 2'd1;
          // A voluntary release on the same edge wins over the timeout.
          if (req[gnt_id]) begin
            timeout_nxt = 1'b1;
            excl_nxt    = gnt;
          end
        end else begin
          // Only reached below HOLD_LAST, so the counter never wraps.
          hold_cnt_nxt = hold_cnt + CW'(1);
        end
      end

      default: begin
        state_nxt  = IDLE;
        gnt_nxt    = '0;
        gnt_id_nxt = '0;
        excl_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      rr_ptr   <= '0;
      excl     <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      hold_cnt <= hold_cnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
      excl     <= excl_nxt;
      timeout  <= timeout_nxt;
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: tb/tb_req_arbiter.sv
// Purpose : self-checking bench for req_arbiter against a behavioural ownership model.
// Latency : model advances on each rising edge; outputs compared every falling edge and at directed points.
// Backpressure: n/a (bench drives en/req directly).
module tb_req_arbiter;

  localparam int MAX_HOLD = 16;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en      = 1'b0;
  logic       rr_mode = 1'b0;
  logic [3:0] req     = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  req_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rr_mode   (rr_mode),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Model: who owns the resource, how many grant cycles it has had, who is
  // barred from the next pick, and where the round-robin scan starts.
  int m_owner = -1;
  int m_held  = 0;
  int m_block = -1;
  int m_start = 0;
  int m_win   = -1;
  bit m_to    = 1'b0;

  function automatic int pick(input logic [3:0] r, input bit rr, input int start, input int block);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = rr ? (start + k) % 4 : 3 - k;
      if (r[idx] && idx != block) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_held  = 0;
      m_block = -1;
      m_start = 0;
      m_to    = 1'b0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || m_held == MAX_HOLD) begin
        m_to = req[m_owner];
        if (m_to) m_block = m_owner;
        m_start = (m_owner + 1) % 4;
        m_owner = -1;
        m_held  = 0;
      end else begin
        m_held++;
        m_to = 1'b0;
      end
    end else begin
      m_to    = 1'b0;
      m_win   = en ? pick(req, rr_mode, m_start, m_block) : -1;
      m_block = -1;
      if (m_win >= 0) begin
        m_owner = m_win;
        m_held  = 1;
      end
    end
  end

  function automatic logic [7:0] model_out();
    logic [3:0] g;
    logic [1:0] id;
    g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    id = (m_owner >= 0) ? 2'(m_owner) : 2'b00;
    return {g, id, |g, m_to};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {gnt,id,vld,to}=%b, expected %b", name, act, exp);
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string name, input logic [3:0] g, input logic [1:0] id, input logic to);
    logic [7:0] e;
    e = {g, id, |g, to};
    chk({name, " dut"}, {gnt, gnt_id, gnt_valid, timeout}, e);
    chk({name, " model"}, model_out(), e);
  endtask

  always @(negedge clk) begin
    chk("cycle", {gnt, gnt_id, gnt_valid, timeout}, model_out());
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    step();
    step();
    lit("reset", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Fixed priority, release and 1-cycle gap.
    req = 4'b0101;
    step(); lit("t1 grant2", 4'b0100, 2'd2, 1'b0);
    req = 4'b0001;
    step(); lit("t1 gap", 4'b0000, 2'd0, 1'b0);
    step(); lit("t1 grant0", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    step();
    step();

    // Restart with rr_ptr=0 for the round-robin sequence.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    rr_mode = 1'b1;
    req     = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      lit($sformatf("t2 grant%0d", i), 4'(1 << (i % 4)), 2'(i % 4), 1'b0);
      step();
      step();
      req = 4'b1111 & ~4'(1 << (i % 4));
      step(); lit($sformatf("t2 gap%0d", i), 4'b0000, 2'd0, 1'b0);
      req = 4'b1111;
      step();
    end
    req = 4'b0000;
    step();
    step();

    // Timeout with a lone requester.
    rr_mode = 1'b0;
    req     = 4'b1000;
    step(); lit("t3 hold1", 4'b1000, 2'd3, 1'b0);
    for (int c = 2; c <= MAX_HOLD; c++) begin
      step(); lit($sformatf("t3 hold%0d", c), 4'b1000, 2'd3, 1'b0);
    end
    step(); lit("t3 timeout", 4'b0000, 2'd0, 1'b1);
    step(); lit("t3 idle", 4'b0000, 2'd0, 1'b0);
    step(); lit("t3 regrant", 4'b1000, 2'd3, 1'b0);

    // Timeout with a competitor: the timed-out owner is skipped once.
    req = 4'b1001;
    for (int c = 2; c <= MAX_HOLD; c++) step();
    step(); lit("t4 timeout", 4'b0000, 2'd0, 1'b1);
    step(); lit("t4 competitor", 4'b0001, 2'd0, 1'b0);

    // en gating.
    en = 1'b0;
    step(); lit("t5 held", 4'b0001, 2'd0, 1'b0);
    req = 4'b1000;
    step(); lit("t5 gap", 4'b0000, 2'd0, 1'b0);
    step(); lit("t5 idle1", 4'b0000, 2'd0, 1'b0);
    step(); lit("t5 idle2", 4'b0000, 2'd0, 1'b0);
    en = 1'b1;
    step(); lit("t5 en", 4'b1000, 2'd3, 1'b0);

    // Asynchronous reset between edges while busy.
    step();
    #1;
    rst_n = 1'b0;
    #1;
    lit("t6 async", 4'b0000, 2'd0, 1'b0);
    step();
    rst_n   = 1'b1;
    rr_mode = 1'b1;
    req     = 4'b1010;
    step(); lit("t6 rr", 4'b0010, 2'd1, 1'b0);

    req = 4'b0000;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
